// File: rtl/uart_rx_buffer_controller.sv
// UART receive-side buffer controller: frame watchdog, shadowed receiver
// configuration and a first-word-fall-through receive FIFO with overrun flag.
module uart_rx_buffer_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic                          serial_data_in,
  input  logic                          cfg_write,
  input  logic                          cfg_parity_enable,
  input  logic                          cfg_parity_type,
  input  logic [5:0]                    cfg_prescale,
  output logic                          parity_enable,
  output logic                          parity_type,
  output logic [5:0]                    prescale,
  output logic                          cfg_pending,
  input  logic                          rx_data_valid,
  input  logic [DATA_WIDTH-1:0]         rx_parallel_data,
  input  logic                          rx_parity_error,
  input  logic                          rx_frame_error,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_parity_error,
  output logic                          rd_frame_error,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          overrun_clear,
  output logic                          rx_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(64 * (DATA_WIDTH + 3)) + 1;
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [5:0]    PSC_RST    = 6'd8;
  localparam logic [TW-1:0] FRAME_BITS = TW'(DATA_WIDTH + 3);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE,
    S_FRAME
  } state_t;

  state_t         state_q;
  logic [TW-1:0]  timer_q;
  logic           timeout_q;

  logic           pe_q, pe_d;
  logic           pt_q, pt_d;
  logic [5:0]     psc_q, psc_d;
  logic           sh_pe_q, sh_pe_d;
  logic           sh_pt_q, sh_pt_d;
  logic [5:0]     sh_psc_q, sh_psc_d;
  logic           pend_q, pend_d;
  logic           apply;

  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovr_q, ovr_d;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           ovr_set;
  logic [EW-1:0]  head;

  logic [5:0]     psc_eff;
  logic [TW-1:0]  limit;

  // Frame length in UCLK cycles; prescale 0 falls back to the reset rate
  always_comb begin
    psc_eff = (psc_q == 6'd0) ? PSC_RST : psc_q;
    limit   = {{(TW-6){1'b0}}, psc_eff} * FRAME_BITS - TW'(1);
  end

  // Frame watchdog: start on line low, end on data or on expiry
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (!serial_data_in) begin
            state_q <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (rx_data_valid) begin
            state_q <= S_IDLE;
          end else if (timer_q == limit) begin
            state_q   <= S_IDLE;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  // Shadow config is promoted only between frames
  always_comb begin
    apply    = (state_q == S_IDLE) && pend_q;
    pe_d     = pe_q;
    pt_d     = pt_q;
    psc_d    = psc_q;
    sh_pe_d  = sh_pe_q;
    sh_pt_d  = sh_pt_q;
    sh_psc_d = sh_psc_q;
    pend_d   = pend_q;
    if (apply) begin
      pe_d   = sh_pe_q;
      pt_d   = sh_pt_q;
      psc_d  = sh_psc_q;
      pend_d = 1'b0;
    end
    if (cfg_write) begin
      sh_pe_d  = cfg_parity_enable;
      sh_pt_d  = cfg_parity_type;
      sh_psc_d = cfg_prescale;
      pend_d   = 1'b1;
    end
  end

  // Active and shadow configuration registers
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      psc_q    <= PSC_RST;
      sh_pe_q  <= 1'b0;
      sh_pt_q  <= 1'b0;
      sh_psc_q <= PSC_RST;
      pend_q   <= 1'b0;
    end else begin
      pe_q     <= pe_d;
      pt_q     <= pt_d;
      psc_q    <= psc_d;
      sh_pe_q  <= sh_pe_d;
      sh_pt_q  <= sh_pt_d;
      sh_psc_q <= sh_psc_d;
      pend_q   <= pend_d;
    end
  end

  // FIFO control: a pop frees the slot a same-cycle push needs
  always_comb begin
    full    = (cnt_q == DEPTH_C);
    empty   = (cnt_q == '0);
    pop     = rd_en && !empty;
    push    = rx_data_valid && (!full || pop);
    ovr_set = rx_data_valid && full && !pop;
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (overrun_clear) begin
      ovr_d = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
    end
  end

  // FIFO storage, entry = {frame_err, parity_err, data}
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q] <= {rx_frame_error, rx_parity_error, rx_parallel_data};
    end
  end

  assign head            = mem_q[rptr_q];
  assign rd_data         = head[DATA_WIDTH-1:0];
  assign rd_parity_error = head[DATA_WIDTH];
  assign rd_frame_error  = head[DATA_WIDTH+1];

  assign fifo_empty    = empty;
  assign fifo_full     = full;
  assign fifo_count    = cnt_q;
  assign overrun       = ovr_q;
  assign rx_timeout    = timeout_q;
  assign parity_enable = pe_q;
  assign parity_type   = pt_q;
  assign prescale      = psc_q;
  assign cfg_pending   = pend_q;

endmodule

// File: doc/uart_rx_buffer_controller.md
UART_RX_BUFFER_CONTROLLER -- requirements
Module: uart_rx_buffer_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: receiver data word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of 2, >= 2.
REQ-003 SHALL have port UCLK  input  1: single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port serial_data_in  input  1: raw RX line, idle high.
REQ-006 SHALL have port cfg_write  input  1: one-cycle strobe capturing cfg_* into shadow config.
REQ-007 SHALL have ports cfg_parity_enable, cfg_parity_type  input  1 each, and cfg_prescale  input  6: requested receiver config.
REQ-008 SHALL have port parity_enable, parity_type  output  1 each, and prescale  output  6: active config driven to the receiver.
REQ-009 SHALL have port cfg_pending  output  1: shadow config captured but not yet applied.
REQ-010 SHALL have ports rx_data_valid  input  1, rx_parallel_data  input  DATA_WIDTH, rx_parity_error, rx_frame_error  input  1 each: receiver results, all valid in the rx_data_valid cycle.
REQ-011 SHALL have ports rd_en  input  1, rd_data  output  DATA_WIDTH, rd_parity_error, rd_frame_error  output  1 each: first-word-fall-through read port.
REQ-012 SHALL have ports fifo_empty, fifo_full  output  1 each, and fifo_count  output  $clog2(FIFO_DEPTH)+1.
REQ-013 SHALL have ports overrun  output  1 (sticky) and overrun_clear  input  1.
REQ-014 SHALL have port rx_timeout  output  1: one-cycle pulse on frame abort.

Function
REQ-015 FSM SHALL have states IDLE and FRAME; reset state IDLE.
REQ-016 IDLE -> FRAME when serial_data_in == 0; frame timer cleared to 0 on entry.
REQ-017 In FRAME, timer SHALL increment by 1 per cycle; width $clog2(64*(DATA_WIDTH+3))+1, no wrap before limit.
REQ-018 FRAME -> IDLE on rx_data_valid; rx_timeout stays 0.
REQ-019 FRAME -> IDLE when timer == prescale*(DATA_WIDTH+3) - 1 with no rx_data_valid; rx_timeout = 1 in the following cycle only.
REQ-020 prescale == 0 SHALL use limit 8*(DATA_WIDTH+3) - 1.
REQ-021 rx_data_valid and the timeout limit in the same cycle SHALL count as a completed frame: data pushed, no rx_timeout.
REQ-022 cfg_write SHALL load shadow and set cfg_pending at the next edge; a later cfg_write while pending SHALL overwrite the shadow.
REQ-023 Shadow SHALL be applied to parity_enable/parity_type/prescale and cfg_pending cleared at any edge where state == IDLE and cfg_pending == 1, including the edge at which IDLE -> FRAME.
REQ-024 Active config SHALL never change while state == FRAME.
REQ-025 cfg_write coincident with an apply edge SHALL apply the old shadow; the new value is captured and remains pending.
REQ-026 rx_data_valid in any state SHALL push {rx_frame_error, rx_parity_error, rx_parallel_data} if not full.
REQ-027 Push when full and no pop SHALL discard the word and set overrun at the next edge.
REQ-028 Push and pop in the same cycle SHALL both occur, including when full; count unchanged.
REQ-029 rd_en when fifo_empty SHALL be ignored, with no pointer or count change.
REQ-030 rd_data/rd_*_error SHALL show the head entry combinationally whenever fifo_empty == 0; value undefined when empty.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_full = (count == FIFO_DEPTH); fifo_empty = (count == 0).
REQ-032 overrun_clear SHALL clear overrun; a new overrun in the same cycle SHALL win (overrun stays 1).

Reset
REQ-033 On reset low, asynchronously: state IDLE, timer 0, FIFO empty, fifo_count 0, overrun 0, rx_timeout 0, cfg_pending 0.
REQ-034 Reset values SHALL be prescale = 8, parity_enable = 0, parity_type = 0, shadow equal to these.
REQ-035 Reset mid-frame SHALL discard FIFO contents and pending config; no push or timeout is produced afterwards for that frame.

Verification
REQ-036 Bench SHALL cover: prescale = 8, line low, rx_data_valid with 0xA5 after 80 cycles -> fifo_count 1, rd_data 0xA5, errors 0, rx_timeout never 1.
REQ-037 Bench SHALL cover: cfg_write prescale = 16 during FRAME -> prescale stays 8 and cfg_pending = 1 until FRAME -> IDLE, then prescale = 16 and cfg_pending = 0 at the next edge.
REQ-038 Bench SHALL cover: prescale = 8, line low, no rx_data_valid -> single rx_timeout pulse the cycle after timer == 87; state IDLE; fifo_count unchanged.
REQ-039 Bench SHALL cover: 5 pushes with DEPTH 4 and no reads -> fifo_full = 1, overrun = 1, the first 4 words read back in order; 5th word absent.
REQ-040 Bench SHALL cover: full FIFO with push and rd_en in the same cycle -> count stays 4, head advances, new word at tail; overrun not set.
REQ-041 Bench SHALL cover: rx_data_valid with rx_parity_error = 1 and rx_frame_error = 1, data 0x3C -> head shows 0x3C with both error flags set; rd_en -> fifo_empty = 1.
